// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) definitions used by both the encoder and the receive side.
// Codeword layout c[6:0] = {d3,d2,d1,p4,d0,p2,p1}; c[k] is bit position k+1.
package hamming_pkg;

  localparam int CW_W   = 7;
  localparam int DATA_W = 4;
  localparam int SYN_W  = 3;

  // Bit index of each field inside the codeword.
  localparam int P1 = 0;
  localparam int P2 = 1;
  localparam int D0 = 2;
  localparam int P4 = 3;
  localparam int D1 = 4;
  localparam int D2 = 5;
  localparam int D3 = 6;

  // Decoded result of one codeword.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [SYN_W-1:0]  err_pos;
    logic              corrected;
  } dec_t;

  // Syndrome {s4,s2,s1}: each parity bit re-checked over the positions it covers.
  function automatic logic [SYN_W-1:0] syndrome(input logic [CW_W-1:0] c);
    logic [SYN_W-1:0] s;
    s[0] = c[P1] ^ c[D0] ^ c[D1] ^ c[D3];
    s[1] = c[P2] ^ c[D0] ^ c[D2] ^ c[D3];
    s[2] = c[P4] ^ c[D1] ^ c[D2] ^ c[D3];
    return s;
  endfunction

  // Pull the four data bits out of a codeword.
  function automatic logic [DATA_W-1:0] extract_data(input logic [CW_W-1:0] c);
    return {c[D3], c[D2], c[D1], c[D0]};
  endfunction

endpackage

// File: rtl/hamming74_correct.sv
// Combinational Hamming(7,4) single-error corrector.
// A non-zero syndrome names the flipped bit position; that bit is inverted
// before the data bits are extracted. Double errors miscorrect silently.
module hamming74_correct
  import hamming_pkg::*;
(
  input  logic [CW_W-1:0]   c_i,
  output logic [DATA_W-1:0] data_o,
  output logic [SYN_W-1:0]  err_pos_o,
  output logic              corrected_o
);

  logic [SYN_W-1:0] syn;
  logic [CW_W-1:0]  flip;
  logic [CW_W-1:0]  fixed;

  assign syn = syndrome(c_i);

  // One-hot mask of the bit to invert; empty when the syndrome is clean.
  always_comb begin
    flip = '0;
    if (syn != '0) flip[syn - 3'd1] = 1'b1;
  end

  assign fixed       = c_i ^ flip;
  assign data_o      = extract_data(fixed);
  assign err_pos_o   = syn;
  assign corrected_o = (syn != '0);

endmodule

// File: rtl/hamming_serial_rx.sv
// Serial receive end of the Hamming(7,4) link.
// Frames a 1-bit stream into 7-bit codewords, corrects single-bit errors and
// presents the nibble on a valid/ready port with a one-entry holding register.
// The 7th bit of a frame is the only one that can stall: it is accepted only
// when the holding register is free or being drained in the same cycle.
module hamming_serial_rx
  import hamming_pkg::*;
#(
  parameter int unsigned CNT_W     = 16,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sync,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic              bit_ready,
  output logic [3:0]        data_out,
  output logic              corrected,
  output logic [2:0]        err_pos,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  corr_count
);

  localparam logic [2:0] LAST_BIT = 3'd6;

  // Framing state
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [CW_W-1:0] sh_q, sh_d;

  // Output holding register
  dec_t            out_q, out_d;
  logic            out_valid_q, out_valid_d;
  logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d;

  // Datapath helpers
  logic            accept;
  logic            last_bit;
  logic            load;
  logic [CW_W-1:0] sh_base;
  logic [CW_W-1:0] cw_full;
  dec_t            dec;

  // Handshake: a bit is taken unless it would complete a frame while the
  // output register is full and not being drained.
  assign last_bit  = (bit_cnt_q == LAST_BIT);
  assign bit_ready = !last_bit || !out_valid_q || out_ready;
  assign accept    = bit_valid && bit_ready;
  // sync wins over a completing bit: that bit starts the next frame instead.
  assign load      = accept && last_bit && !sync;

  // Shift-register contents after sync discard, and with the new bit shifted in.
  // LSB-first streams enter at the top and walk down so the first bit ends in c[0];
  // MSB-first streams enter at the bottom so the first bit ends in c[6].
  always_comb begin
    sh_base = sync ? '0 : sh_q;
    if (LSB_FIRST) cw_full = {bit_in, sh_base[CW_W-1:1]};
    else           cw_full = {sh_base[CW_W-2:0], bit_in};
  end

  // Decode the completed codeword straight from the shifter plus the incoming bit
  // so the result can be registered in the same cycle the 7th bit is accepted.
  hamming74_correct u_correct (
    .c_i         (cw_full),
    .data_o      (dec.data),
    .err_pos_o   (dec.err_pos),
    .corrected_o (dec.corrected)
  );

  // Next-state framing: bit counter runs 0..6 and wraps; sync restarts it.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    sh_d      = sh_base;
    if (accept) sh_d = cw_full;
    if (sync) begin
      bit_cnt_d = accept ? 3'd1 : 3'd0;
    end else if (accept) begin
      bit_cnt_d = last_bit ? 3'd0 : bit_cnt_q + 3'd1;
    end
  end

  // Next-state output register and saturating corrected-word counter.
  // A load in the same cycle as a drain keeps out_valid set.
  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    corr_cnt_d  = corr_cnt_q;
    if (load) begin
      out_d       = dec;
      out_valid_d = 1'b1;
      if (dec.corrected && !(&corr_cnt_q)) corr_cnt_d = corr_cnt_q + CNT_W'(1);
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q   <= '0;
      sh_q        <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      corr_cnt_q  <= '0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      sh_q        <= sh_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      corr_cnt_q  <= corr_cnt_d;
    end
  end

  assign data_out   = out_q.data;
  assign err_pos    = out_q.err_pos;
  assign corrected  = out_q.corrected;
  assign out_valid  = out_valid_q;
  assign corr_count = corr_cnt_q;

endmodule

// File: tb/tb_hamming_serial_rx.sv
// Bench for hamming_serial_rx: three instances share one stimulus stream
// (LSB-first 16-bit counter, LSB-first 2-bit counter, MSB-first) and are
// compared each cycle against a frame-queue reference model.
module tb_hamming_serial_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, sync, bit_in, bit_valid, out_ready;

  logic        br_a, ov_a, co_a;
  logic [3:0]  d_a;
  logic [2:0]  e_a;
  logic [15:0] cnt_a;

  logic        br_s, ov_s, co_s;
  logic [3:0]  d_s;
  logic [2:0]  e_s;
  logic [1:0]  cnt_s;

  logic        br_m, ov_m, co_m;
  logic [3:0]  d_m;
  logic [2:0]  e_m;
  logic [15:0] cnt_m;

  hamming_serial_rx #(.CNT_W(16), .LSB_FIRST(1'b1)) u_a (
    .clk(clk), .rst(rst), .sync(sync), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(br_a), .data_out(d_a), .corrected(co_a), .err_pos(e_a),
    .out_valid(ov_a), .out_ready(out_ready), .corr_count(cnt_a));

  hamming_serial_rx #(.CNT_W(2), .LSB_FIRST(1'b1)) u_s (
    .clk(clk), .rst(rst), .sync(sync), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(br_s), .data_out(d_s), .corrected(co_s), .err_pos(e_s),
    .out_valid(ov_s), .out_ready(out_ready), .corr_count(cnt_s));

  hamming_serial_rx #(.CNT_W(16), .LSB_FIRST(1'b0)) u_m (
    .clk(clk), .rst(rst), .sync(sync), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(br_m), .data_out(d_m), .corrected(co_m), .err_pos(e_m),
    .out_valid(ov_m), .out_ready(out_ready), .corr_count(cnt_m));

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit       q[$];
  bit       mv;
  bit [3:0] md, mdm;
  bit [2:0] me, mem;
  int       mcnt, mcntm;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Syndrome as the XOR of the 1-based positions of all set bits.
  task automatic decode(input bit [6:0] c, output bit [3:0] d, output bit [2:0] p);
    bit [6:0] cc;
    int s;
    cc = c;
    s  = 0;
    for (int k = 0; k < 7; k++) if (cc[k]) s = s ^ (k + 1);
    if (s != 0) cc[s-1] = ~cc[s-1];
    p = 3'(s);
    d = {cc[6], cc[5], cc[4], cc[2]};
  endtask

  task automatic model_reset();
    q.delete();
    mv = 0; md = 0; mdm = 0; me = 0; mem = 0; mcnt = 0; mcntm = 0;
  endtask

  // One clock cycle: drive on the falling edge, check, then advance the model.
  task automatic step(input bit v, input bit b, input bit s, input bit r, input bit orr);
    bit       exp_ready, acc;
    bit [6:0] c, cm;
    @(negedge clk);
    bit_valid = v; bit_in = b; sync = s; rst = r; out_ready = orr;
    #1;
    exp_ready = (q.size() != 6) || !mv || orr;
    chk("a.bit_ready", 32'(br_a), 32'(exp_ready));
    chk("s.bit_ready", 32'(br_s), 32'(exp_ready));
    chk("m.bit_ready", 32'(br_m), 32'(exp_ready));
    chk("a.out_valid", 32'(ov_a), 32'(mv));
    chk("s.out_valid", 32'(ov_s), 32'(mv));
    chk("m.out_valid", 32'(ov_m), 32'(mv));
    chk("a.data", 32'(d_a), 32'(md));
    chk("a.err_pos", 32'(e_a), 32'(me));
    chk("a.corrected", 32'(co_a), 32'(me != 0));
    chk("s.data", 32'(d_s), 32'(md));
    chk("m.data", 32'(d_m), 32'(mdm));
    chk("m.err_pos", 32'(e_m), 32'(mem));
    chk("m.corrected", 32'(co_m), 32'(mem != 0));
    chk("a.corr_count", 32'(cnt_a), 32'((mcnt > 65535) ? 65535 : mcnt));
    chk("s.corr_count", 32'(cnt_s), 32'((mcnt > 3) ? 3 : mcnt));
    chk("m.corr_count", 32'(cnt_m), 32'((mcntm > 65535) ? 65535 : mcntm));
    if (r) begin
      model_reset();
    end else begin
      acc = v && exp_ready;
      if (s) q.delete();
      if (acc) q.push_back(b);
      if (q.size() == 7) begin
        for (int i = 0; i < 7; i++) begin
          c[i]    = q[i];
          cm[6-i] = q[i];
        end
        decode(c, md, me);
        decode(cm, mdm, mem);
        if (me != 0) mcnt++;
        if (mem != 0) mcntm++;
        mv = 1;
        q.delete();
      end else if (mv && orr) begin
        mv = 0;
      end
    end
  endtask

  task automatic send_cw(input bit [6:0] cw, input bit orr);
    for (int i = 0; i < 7; i++) step(1, cw[i], 0, 0, orr);
  endtask

  typedef struct {
    bit [6:0] cw;
    bit [3:0] d;
    bit [2:0] e;
    bit       c;
  } vec_t;

  vec_t tbl[9];
  int   nval, ready_low;
  bit [3:0] seen[$];

  initial begin
    tbl[0] = '{7'b0000111, 4'b0001, 3'd0, 1'b0};
    tbl[1] = '{7'b1100110, 4'b1101, 3'd0, 1'b0};
    tbl[2] = '{7'b1110111, 4'b1111, 3'd4, 1'b1};
    tbl[3] = '{7'b0000000, 4'b0000, 3'd0, 1'b0};
    tbl[4] = '{7'b1111111, 4'b1111, 3'd0, 1'b0};
    tbl[5] = '{7'b0000001, 4'b0000, 3'd1, 1'b1};
    tbl[6] = '{7'b1000000, 4'b0000, 3'd7, 1'b1};
    tbl[7] = '{7'b0000011, 4'b0001, 3'd3, 1'b1};  // double error miscorrects
    tbl[8] = '{7'b1100100, 4'b1101, 3'd2, 1'b1};

    rst = 1; sync = 0; bit_in = 0; bit_valid = 0; out_ready = 0;
    model_reset();
    @(posedge clk);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    chk("reset.out_valid", 32'(ov_a), 32'd0);
    chk("reset.data", 32'(d_a), 32'd0);
    chk("reset.err_pos", 32'(e_a), 32'd0);
    chk("reset.corr_count", 32'(cnt_a), 32'd0);

    // Table of single codewords
    for (int t = 0; t < 9; t++) begin
      send_cw(tbl[t].cw, 1);
      step(0, 0, 0, 0, 0);
      chk("tbl.valid", 32'(ov_a), 32'd1);
      chk("tbl.data", 32'(d_a), 32'(tbl[t].d));
      chk("tbl.err_pos", 32'(e_a), 32'(tbl[t].e));
      chk("tbl.corrected", 32'(co_a), 32'(tbl[t].c));
    end
    chk("tbl.corr_count16", 32'(cnt_a), 32'd5);
    chk("tbl.corr_count_sat", 32'(cnt_s), 32'd3);

    // Back-to-back clean codewords with out_ready held high
    step(0, 0, 0, 1, 0);
    nval = 0; ready_low = 0; seen.delete();
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 7; i++) begin
        step(1, tbl[f].cw[i], 0, 0, 1);
        if (!br_a) ready_low++;
        if (ov_a) begin nval++; seen.push_back(d_a); end
      end
    end
    step(0, 0, 0, 0, 1);
    if (ov_a) begin nval++; seen.push_back(d_a); end
    chk("b2b.count", 32'(nval), 32'd2);
    chk("b2b.ready_low", 32'(ready_low), 32'd0);
    if (seen.size() == 2) begin
      chk("b2b.first", 32'(seen[0]), 32'b0001);
      chk("b2b.second", 32'(seen[1]), 32'b1101);
    end else begin
      chk("b2b.seen_size", 32'(seen.size()), 32'd2);
    end

    // Backpressure: second codeword's 7th bit stalls until out_ready rises
    step(0, 0, 0, 0, 0);
    send_cw(tbl[0].cw, 0);
    for (int i = 0; i < 6; i++) step(1, tbl[1].cw[i], 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(1, tbl[1].cw[6], 0, 0, 0);
      chk("bp.stall", 32'(br_a), 32'd0);
      chk("bp.hold_data", 32'(d_a), 32'b0001);
      chk("bp.hold_valid", 32'(ov_a), 32'd1);
    end
    step(1, tbl[1].cw[6], 0, 0, 1);
    chk("bp.release", 32'(br_a), 32'd1);
    step(0, 0, 0, 0, 0);
    chk("bp.second_valid", 32'(ov_a), 32'd1);
    chk("bp.second_data", 32'(d_a), 32'b1101);

    // sync after 3 bits, then a clean frame starting on the sync cycle
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 1'b1, 0, 0, 1);
    nval = 0; seen.delete();
    step(1, tbl[1].cw[0], 1, 0, 1);
    for (int i = 1; i < 7; i++) step(1, tbl[1].cw[i], 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 0, 1);
      if (ov_a) begin nval++; seen.push_back(d_a); end
    end
    chk("sync.count", 32'(nval), 32'd1);
    if (seen.size() > 0) chk("sync.data", 32'(seen[0]), 32'b1101);

    // sync coincident with a 7th bit produces no output
    for (int i = 0; i < 6; i++) step(1, tbl[0].cw[i], 0, 0, 1);
    nval = 0;
    step(1, tbl[0].cw[6], 1, 0, 1);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 0, 1);
      if (ov_a) nval++;
    end
    chk("sync7.count", 32'(nval), 32'd0);

    // Reset with 4 bits in flight and a pending output
    step(0, 0, 0, 1, 0);
    send_cw(tbl[2].cw, 0);
    for (int i = 0; i < 4; i++) step(1, tbl[1].cw[i], 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    chk("rst.out_valid", 32'(ov_a), 32'd0);
    chk("rst.data", 32'(d_a), 32'd0);
    chk("rst.corrected", 32'(co_a), 32'd0);
    chk("rst.err_pos", 32'(e_a), 32'd0);
    chk("rst.corr_count", 32'(cnt_a), 32'd0);

    // Random traffic against the model
    for (int n = 0; n < 4000; n++) begin
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 40) == 0, $urandom_range(0, 400) == 0,
           $urandom_range(0, 2) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
